// File: rtl/cordic_pkg.sv
// Shared constants and types for the pipelined rotation-mode CORDIC.
// Angles are integer degrees scaled by 2^FRAC.
package cordic_pkg;

    localparam int unsigned ITER = 16;
    localparam int unsigned DW   = 32;
    localparam int unsigned FRAC = 16;
    localparam int unsigned AW   = 16;

    localparam int          CORDIC_K = 39797;
    localparam int unsigned MAX_DEG  = 90;

    // round(atan(2^-i) * 180/pi * 2^16)
    localparam int ATAN [0:ITER-1] = '{
        2949120, 1740967, 919879, 466945, 234379, 117304, 58666, 29335,
        14668,   7334,    3667,   1833,   917,    458,    229,   115
    };

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quad_e;

endpackage

// File: rtl/cordic_stage.sv
// One registered CORDIC micro-rotation; x/y/z/quadrant ride along with valid.
module cordic_stage
    import cordic_pkg::quad_e;
#(
    parameter int unsigned DW       = 32,
    parameter int unsigned SHIFT    = 0,
    parameter int          ATAN_VAL = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 vld_i,
    input  logic signed [DW-1:0] x_i,
    input  logic signed [DW-1:0] y_i,
    input  logic signed [DW-1:0] z_i,
    input  quad_e                q_i,
    output logic                 vld_o,
    output logic signed [DW-1:0] x_o,
    output logic signed [DW-1:0] y_o,
    output logic signed [DW-1:0] z_o,
    output quad_e                q_o
);

    logic                 vld_q;
    logic signed [DW-1:0] x_q, y_q, z_q;
    logic signed [DW-1:0] x_d, y_d, z_d;
    logic signed [DW-1:0] x_sh_c, y_sh_c;
    quad_e                q_q;

    // Rotate toward z = 0: positive residual rotates counter-clockwise.
    always_comb begin
        x_sh_c = x_i >>> SHIFT;
        y_sh_c = y_i >>> SHIFT;
        x_d    = x_i;
        y_d    = y_i;
        z_d    = z_i;
        if (!z_i[DW-1]) begin
            x_d = x_i - y_sh_c;
            y_d = y_i + x_sh_c;
            z_d = z_i - DW'(ATAN_VAL);
        end else begin
            x_d = x_i + y_sh_c;
            y_d = y_i - x_sh_c;
            z_d = z_i + DW'(ATAN_VAL);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= 1'b0;
        end else begin
            vld_q <= vld_i;
        end
    end

    always_ff @(posedge clk) begin
        x_q <= x_d;
        y_q <= y_d;
        z_q <= z_d;
        q_q <= q_i;
    end

    assign vld_o = vld_q;
    assign x_o   = x_q;
    assign y_o   = y_q;
    assign z_o   = z_q;
    assign q_o   = q_q;

endmodule

// File: rtl/cordic.sv
// Pipelined CORDIC: clamp/register phase, ITER micro-rotations, quadrant map.
// One phase accepted per clock, results emerge in order after ITER+2 registers.
module cordic #(
    parameter int unsigned ITER = cordic_pkg::ITER,
    parameter int unsigned DW   = cordic_pkg::DW,
    parameter int unsigned FRAC = cordic_pkg::FRAC
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_vld,
    input  logic [31:0]   phase,
    output logic          out_vld,
    output logic [DW-1:0] sin,
    output logic [DW-1:0] cos,
    output logic [DW-1:0] error
);
    import cordic_pkg::*;

    logic [AW-1:0]        ang_c;
    logic                 unused_phase_c;
    logic                 vld0_q;
    logic signed [DW-1:0] x0_q, y0_q, z0_q;
    quad_e                q0_q;

    logic                 vld_s [0:ITER];
    logic signed [DW-1:0] x_s   [0:ITER];
    logic signed [DW-1:0] y_s   [0:ITER];
    logic signed [DW-1:0] z_s   [0:ITER];
    quad_e                q_s   [0:ITER];

    logic signed [DW-1:0] sin_d, cos_d;
    logic signed [DW-1:0] sin_q, cos_q, err_q;
    logic                 out_vld_q;

    assign unused_phase_c = ^phase[31:18];
    assign ang_c = (phase[AW-1:0] > AW'(MAX_DEG)) ? AW'(MAX_DEG) : phase[AW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            vld0_q <= 1'b0;
        end else begin
            vld0_q <= in_vld;
        end
    end

    always_ff @(posedge clk) begin
        x0_q <= DW'(CORDIC_K);
        y0_q <= '0;
        z0_q <= DW'(ang_c) << FRAC;
        q0_q <= quad_e'(phase[17:16]);
    end

    assign vld_s[0] = vld0_q;
    assign x_s[0]   = x0_q;
    assign y_s[0]   = y0_q;
    assign z_s[0]   = z0_q;
    assign q_s[0]   = q0_q;

    for (genvar i = 0; i < ITER; i++) begin : g_stage
        cordic_stage #(
            .DW       (DW),
            .SHIFT    (i),
            .ATAN_VAL (ATAN[i])
        ) u_stage (
            .clk   (clk),
            .rst   (rst),
            .vld_i (vld_s[i]),
            .x_i   (x_s[i]),
            .y_i   (y_s[i]),
            .z_i   (z_s[i]),
            .q_i   (q_s[i]),
            .vld_o (vld_s[i+1]),
            .x_o   (x_s[i+1]),
            .y_o   (y_s[i+1]),
            .z_o   (z_s[i+1]),
            .q_o   (q_s[i+1])
        );
    end

    // First-quadrant (s, c) rotated into the requested quadrant.
    always_comb begin
        sin_d = y_s[ITER];
        cos_d = x_s[ITER];
        case (q_s[ITER])
            Q0: begin
                sin_d = y_s[ITER];
                cos_d = x_s[ITER];
            end
            Q1: begin
                sin_d = x_s[ITER];
                cos_d = -y_s[ITER];
            end
            Q2: begin
                sin_d = -y_s[ITER];
                cos_d = -x_s[ITER];
            end
            Q3: begin
                sin_d = -x_s[ITER];
                cos_d = y_s[ITER];
            end
            default: begin
                sin_d = y_s[ITER];
                cos_d = x_s[ITER];
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld_q <= 1'b0;
            sin_q     <= '0;
            cos_q     <= '0;
            err_q     <= '0;
        end else begin
            out_vld_q <= vld_s[ITER];
            if (vld_s[ITER]) begin
                sin_q <= sin_d;
                cos_q <= cos_d;
                err_q <= z_s[ITER];
            end
        end
    end

    assign out_vld = out_vld_q;
    assign sin     = sin_q;
    assign cos     = cos_q;
    assign error   = err_q;

endmodule

// File: tb/tb_cordic.sv
// Self-checking bench for cordic: trig reference from $sin/$cos with a
// fixed-latency expectation queue, checked every clock.
module tb_cordic;

    localparam int LAT  = 18;
    localparam int TOL  = 16;
    localparam int ZTOL = 256;
    localparam real PI  = 3.14159265358979323846;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_vld;
    logic [31:0] phase;
    logic        out_vld;
    logic [31:0] sin;
    logic [31:0] cos;
    logic [31:0] error;

    cordic dut (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (in_vld),
        .phase   (phase),
        .out_vld (out_vld),
        .sin     (sin),
        .cos     (cos),
        .error   (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        int es;
        int ec;
    } exp_t;

    exp_t pend[$];
    int   cyc       = 0;
    int   n_cmp     = 0;
    int   n_bad     = 0;
    int   last_s    = 0;
    int   last_c    = 0;
    bit   last_zero = 1'b1;

    // Ideal result: angle = 90*q + min(a, 90) degrees, scaled by 2^16.
    function automatic void model(input logic [31:0] ph, output int es, output int ec);
        int  a;
        int  q;
        real rad;
        a = int'(ph[15:0]);
        q = int'(ph[17:16]);
        if (a > 90) a = 90;
        rad = (90.0 * q + a) * PI / 180.0;
        es  = int'($sin(rad) * 65536.0);
        ec  = int'($cos(rad) * 65536.0);
    endfunction

    task automatic chk(input string tag, input int obs, input int expv, input int tol);
        int d;
        d = obs - expv;
        if (d < 0) d = -d;
        n_cmp++;
        assert ((d <= tol) === 1'b1)
        else begin
            n_bad++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d tol=%0d", tag, cyc, obs, expv, tol);
        end
    endtask

    // One clock: drive at negedge, check #1 after the rising edge.
    task automatic tick(input logic r, input logic v, input logic [31:0] ph);
        exp_t e;
        bit   vld_exp;
        @(negedge clk);
        rst    = r;
        in_vld = v;
        phase  = ph;
        if (!r && v) begin
            model(ph, e.es, e.ec);
            e.due = cyc + LAT;
            pend.push_back(e);
        end
        @(posedge clk);
        cyc++;
        if (r) begin
            pend.delete();
            last_zero = 1'b1;
        end
        #1;
        vld_exp = (pend.size() > 0) && (pend[0].due == cyc);
        chk("out_vld", int'(out_vld), int'(vld_exp), 0);
        if (vld_exp) begin
            e         = pend.pop_front();
            last_s    = e.es;
            last_c    = e.ec;
            last_zero = 1'b0;
        end
        if (last_zero) begin
            chk("sin_zero", int'($signed(sin)), 0, 0);
            chk("cos_zero", int'($signed(cos)), 0, 0);
            chk("err_zero", int'($signed(error)), 0, 0);
        end else begin
            chk("sin", int'($signed(sin)), last_s, TOL);
            chk("cos", int'($signed(cos)), last_c, TOL);
            chk("err", int'($signed(error)), 0, ZTOL);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        logic [31:0] ph;
        rst    = 1'b1;
        in_vld = 1'b0;
        phase  = 32'h0;

        // Reset with random inputs, then quiet pipeline.
        tick(1'b1, 1'($urandom), $urandom);
        tick(1'b1, 1'($urandom), $urandom);
        idle(LAT);

        // First quadrant single pulses, each followed by a hold window.
        tick(1'b0, 1'b1, 32'd30);  idle(LAT + 3);
        tick(1'b0, 1'b1, 32'd45);  idle(LAT + 3);
        tick(1'b0, 1'b1, 32'd60);  idle(LAT + 3);
        tick(1'b0, 1'b1, 32'd90);  idle(LAT + 3);
        tick(1'b0, 1'b1, 32'd0);   idle(LAT + 3);

        // Quadrant mapping: 120, 225, 360 degrees.
        tick(1'b0, 1'b1, 32'h0001_001E); idle(LAT + 2);
        tick(1'b0, 1'b1, 32'h0002_002D); idle(LAT + 2);
        tick(1'b0, 1'b1, 32'h0003_005A); idle(LAT + 2);

        // Streaming sweep 0..360 degrees, one per clock.
        for (int d = 0; d <= 360; d++) begin
            if (d == 360) ph = {14'd0, 2'd3, 16'd90};
            else          ph = {14'd0, 2'(d / 90), 16'(d % 90)};
            tick(1'b0, 1'b1, ph);
        end
        idle(LAT + 4);

        // Clamp with junk in the ignored upper bits.
        tick(1'b0, 1'b1, 32'hABCC_00C8); idle(LAT + 4);

        // Random phases with gaps, angles beyond 90 included.
        for (int k = 0; k < 60; k++) begin
            ph = {14'($urandom), 2'($urandom), 16'($urandom_range(0, 120))};
            tick(1'b0, 1'($urandom), ph);
        end
        idle(LAT + 4);

        // Mid-flight reset discards the in-flight result.
        tick(1'b0, 1'b1, 32'd30);
        idle(4);
        tick(1'b1, 1'b0, 32'h0);
        idle(LAT + 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
